// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared widths, constants and helpers for the reorder buffer slice.
//   ROB id      : slot index + 1, so id 0 (NON_DEPENDENT) means "no producer".
//   Register no : EX_REG_W bits; REG_NONE marks an instruction with no dest.
// The companion macros mirror these constants for code that prefers defines.
// Optional feature macro used by this slice: ROB_CDB_BYPASS_EN.
// -----------------------------------------------------------------------------
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef ROB_ID_TYPE
`define ROB_ID_TYPE logic [4:0]
`endif
`ifndef NON_DEPENDENT
`define NON_DEPENDENT 5'd0
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef EX_REG_NUMBER_WIDTH
`define EX_REG_NUMBER_WIDTH 6
`endif
`ifndef REG_NUMBER
`define REG_NUMBER 6'd32
`endif

package reorder_buffer_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int EX_REG_W = 6;

    // Register numbers 0..31 are architectural; 32 means "no destination".
    localparam logic [EX_REG_W-1:0] REG_NONE = 6'd32;

    // A committing entry writes the register file only for a real, non-zero rd.
    function automatic logic rd_writes(input logic [EX_REG_W-1:0] rd);
        return (rd != REG_NONE) && (rd != '0);
    endfunction
endpackage

// File: rtl/rob_operand_query.sv
// -----------------------------------------------------------------------------
// rob_operand_query
// Combinational tag lookup used by the dispatcher for one source operand.
//   tag_i          : ROB id of the producer (0 = no dependency)
//   busy_i/ready_i : per-slot valid and result-present flags
//   value_i        : per-slot captured results
//   cdb_*_i        : live broadcast, consulted only with ROB_CDB_BYPASS_EN
//   ready_o/value_o: operand already available, and its value
// Macro ROB_CDB_BYPASS_EN: forward a same-cycle CDB hit straight to the query.
// -----------------------------------------------------------------------------
module rob_operand_query
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic [ROB_IDX_W:0]  tag_i,
    input  logic [ROB_SIZE-1:0] busy_i,
    input  logic [ROB_SIZE-1:0] ready_i,
    input  logic [DATA_W-1:0]   value_i [ROB_SIZE],
    input  logic                cdb_en_i,
    input  logic [ROB_IDX_W:0]  cdb_rob_id_i,
    input  logic [DATA_W-1:0]   cdb_value_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   value_o
);
    localparam logic [ROB_IDX_W:0] MAX_ID = (ROB_IDX_W+1)'(ROB_SIZE);

    logic                 tag_ok;
    logic [ROB_IDX_W-1:0] idx;

    // Ids 1..ROB_SIZE map to slots 0..ROB_SIZE-1; id ROB_SIZE wraps to slot 0-1.
    assign tag_ok = (tag_i != '0) && (tag_i <= MAX_ID);
    assign idx    = tag_i[ROB_IDX_W-1:0] - ROB_IDX_W'(1);

    always_comb begin
        ready_o = 1'b0;
        value_o = '0;
        if (tag_ok && busy_i[idx]) begin
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_en_i && (cdb_rob_id_i == tag_i)) begin
                ready_o = 1'b1;
                value_o = cdb_value_i;
            end else begin
                ready_o = ready_i[idx];
                value_o = value_i[idx];
            end
`else
            ready_o = ready_i[idx];
            value_o = value_i[idx];
`endif
        end
    end

`ifndef ROB_CDB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = ^{cdb_en_i, cdb_rob_id_i, cdb_value_i};
`endif
endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order-retire reorder buffer.
//   clk, rst (sync, active high), rdy (global enable; low freezes everything)
//   Dispatcher : alloc_en/rd/is_branch/pred_taken/alt_pc in, rob_id/full out,
//                operand queries Qj/Qk -> Qj_ready/Vj, Qk_ready/Vk
//   CDB        : cdb_en, cdb_rob_id, cdb_value, cdb_taken
//   Reg file   : enable_to_reg, rd_to_reg, Q_to_reg, V_to_reg (registered)
//   Flush      : mispredict pulse with redirect_pc
// Macro ROB_CDB_BYPASS_EN: operand queries also see the live CDB.
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 alloc_en_from_dsp,
    input  logic [EX_REG_W-1:0]  rd_from_dsp,
    input  logic                 is_branch_from_dsp,
    input  logic                 pred_taken_from_dsp,
    input  logic [ADDR_W-1:0]    alt_pc_from_dsp,
    output logic [ROB_IDX_W:0]   rob_id_to_dsp,
    output logic                 full_to_dsp,
    input  logic [ROB_IDX_W:0]   Qj_from_dsp,
    input  logic [ROB_IDX_W:0]   Qk_from_dsp,
    output logic                 Qj_ready_to_dsp,
    output logic                 Qk_ready_to_dsp,
    output logic [DATA_W-1:0]    Vj_to_dsp,
    output logic [DATA_W-1:0]    Vk_to_dsp,
    input  logic                 cdb_en,
    input  logic [ROB_IDX_W:0]   cdb_rob_id,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic                 cdb_taken,
    output logic                 enable_to_reg,
    output logic [EX_REG_W-1:0]  rd_to_reg,
    output logic [ROB_IDX_W:0]   Q_to_reg,
    output logic [DATA_W-1:0]    V_to_reg,
    output logic                 mispredict,
    output logic [ADDR_W-1:0]    redirect_pc
);
    localparam logic [ROB_IDX_W:0] MAX_ID = (ROB_IDX_W+1)'(ROB_SIZE);

    // Per-slot state, gathered from the generate blocks below.
    logic [ROB_SIZE-1:0] busy_vec, ready_vec, is_br_vec, pred_vec, taken_vec;
    logic [DATA_W-1:0]   value_arr [ROB_SIZE];
    logic [EX_REG_W-1:0] rd_arr    [ROB_SIZE];
    logic [ADDR_W-1:0]   alt_arr   [ROB_SIZE];

    logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d, cdb_idx;
    logic [ROB_IDX_W:0]   count_q, count_d;
    logic                 enable_q, mispredict_q;
    logic [EX_REG_W-1:0]  rd_out_q;
    logic [ROB_IDX_W:0]   q_out_q;
    logic [DATA_W-1:0]    v_out_q;
    logic [ADDR_W-1:0]    redirect_q;

    logic full, head_commit, head_flush, head_writes, do_alloc, cdb_hit;

    assign full        = (count_q == MAX_ID);
    assign head_commit = busy_vec[head_q] && ready_vec[head_q];
    assign head_flush  = head_commit && is_br_vec[head_q]
                         && (taken_vec[head_q] != pred_vec[head_q]);
    assign head_writes = head_commit && rd_writes(rd_arr[head_q]);
    // Allocation is dropped while flushing and in the cycle of the flush pulse.
    assign do_alloc    = alloc_en_from_dsp && !full && !mispredict_q && !head_flush;
    assign cdb_idx     = cdb_rob_id[ROB_IDX_W-1:0] - ROB_IDX_W'(1);
    assign cdb_hit     = cdb_en && !mispredict_q && (cdb_rob_id != '0)
                         && (cdb_rob_id <= MAX_ID) && busy_vec[cdb_idx];

    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            localparam logic [ROB_IDX_W-1:0] SLOT = ROB_IDX_W'(gi);
            logic                busy_q, ready_q, is_br_q, pred_q, taken_q;
            logic [DATA_W-1:0]   value_q;
            logic [EX_REG_W-1:0] rd_q;
            logic [ADDR_W-1:0]   alt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    is_br_q <= 1'b0;
                    pred_q  <= 1'b0;
                    taken_q <= 1'b0;
                    value_q <= '0;
                    rd_q    <= REG_NONE;
                    alt_q   <= '0;
                end else if (rdy) begin
                    if (head_flush) begin
                        busy_q <= 1'b0;
                    end else if (do_alloc && (tail_q == SLOT)) begin
                        // A free tail slot can never be the head being retired.
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        is_br_q <= is_branch_from_dsp;
                        pred_q  <= pred_taken_from_dsp;
                        taken_q <= 1'b0;
                        value_q <= '0;
                        rd_q    <= rd_from_dsp;
                        alt_q   <= alt_pc_from_dsp;
                    end else begin
                        if (head_commit && (head_q == SLOT)) busy_q <= 1'b0;
                        if (cdb_hit && (cdb_idx == SLOT)) begin
                            ready_q <= 1'b1;
                            value_q <= cdb_value;
                            taken_q <= cdb_taken;
                        end
                    end
                end
            end

            assign busy_vec[gi]  = busy_q;
            assign ready_vec[gi] = ready_q;
            assign is_br_vec[gi] = is_br_q;
            assign pred_vec[gi]  = pred_q;
            assign taken_vec[gi] = taken_q;
            assign value_arr[gi] = value_q;
            assign rd_arr[gi]    = rd_q;
            assign alt_arr[gi]   = alt_q;
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (head_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (head_commit) head_d = head_q + ROB_IDX_W'(1);
            if (do_alloc)    tail_d = tail_q + ROB_IDX_W'(1);
            if (do_alloc && !head_commit)      count_d = count_q + (ROB_IDX_W+1)'(1);
            else if (!do_alloc && head_commit) count_d = count_q - (ROB_IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            enable_q     <= 1'b0;
            rd_out_q     <= REG_NONE;
            q_out_q      <= '0;
            v_out_q      <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else if (rdy) begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            enable_q     <= head_writes;
            mispredict_q <= head_flush;
            if (head_writes) begin
                rd_out_q <= rd_arr[head_q];
                q_out_q  <= {1'b0, head_q} + (ROB_IDX_W+1)'(1);
                v_out_q  <= value_arr[head_q];
            end
            if (head_flush) redirect_q <= alt_arr[head_q];
        end
    end

    rob_operand_query #(.ROB_SIZE(ROB_SIZE), .ROB_IDX_W(ROB_IDX_W)) u_query_j (
        .tag_i(Qj_from_dsp), .busy_i(busy_vec), .ready_i(ready_vec), .value_i(value_arr),
        .cdb_en_i(cdb_en), .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value),
        .ready_o(Qj_ready_to_dsp), .value_o(Vj_to_dsp)
    );

    rob_operand_query #(.ROB_SIZE(ROB_SIZE), .ROB_IDX_W(ROB_IDX_W)) u_query_k (
        .tag_i(Qk_from_dsp), .busy_i(busy_vec), .ready_i(ready_vec), .value_i(value_arr),
        .cdb_en_i(cdb_en), .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value),
        .ready_o(Qk_ready_to_dsp), .value_o(Vk_to_dsp)
    );

    assign rob_id_to_dsp = {1'b0, tail_q} + (ROB_IDX_W+1)'(1);
    assign full_to_dsp   = full;
    assign enable_to_reg = enable_q;
    assign rd_to_reg     = rd_out_q;
    assign Q_to_reg      = q_out_q;
    assign V_to_reg      = v_out_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: one line per transaction, checks via
// immediate assertions, single summary line at the end.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alloc_en;
    logic [5:0]  rd_in;
    logic        is_br, pred;
    logic [31:0] alt_pc;
    logic [4:0]  rob_id;
    logic        full;
    logic [4:0]  qj, qk;
    logic        qj_rdy, qk_rdy;
    logic [31:0] vj, vk;
    logic        cdb_en;
    logic [4:0]  cdb_id;
    logic [31:0] cdb_val;
    logic        cdb_tk;
    logic        en_reg;
    logic [5:0]  rd_reg;
    logic [4:0]  q_reg;
    logic [31:0] v_reg;
    logic        misp;
    logic [31:0] rpc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_en_from_dsp(alloc_en), .rd_from_dsp(rd_in),
        .is_branch_from_dsp(is_br), .pred_taken_from_dsp(pred),
        .alt_pc_from_dsp(alt_pc), .rob_id_to_dsp(rob_id), .full_to_dsp(full),
        .Qj_from_dsp(qj), .Qk_from_dsp(qk),
        .Qj_ready_to_dsp(qj_rdy), .Qk_ready_to_dsp(qk_rdy),
        .Vj_to_dsp(vj), .Vk_to_dsp(vk),
        .cdb_en(cdb_en), .cdb_rob_id(cdb_id), .cdb_value(cdb_val), .cdb_taken(cdb_tk),
        .enable_to_reg(en_reg), .rd_to_reg(rd_reg), .Q_to_reg(q_reg), .V_to_reg(v_reg),
        .mispredict(misp), .redirect_pc(rpc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; alloc_en = 1'b0; rd_in = 6'd32; is_br = 1'b0;
        pred = 1'b0; alt_pc = '0; qj = '0; qk = '0; cdb_en = 1'b0; cdb_id = '0;
        cdb_val = '0; cdb_tk = 1'b0;
        tick(); tick();
        rst = 1'b0;
        $display("reset");
    endtask

    task automatic alloc(input logic [5:0] rd, input logic br, input logic pr,
                         input logic [31:0] apc);
        alloc_en = 1'b1; rd_in = rd; is_br = br; pred = pr; alt_pc = apc;
        tick();
        alloc_en = 1'b0; is_br = 1'b0; pred = 1'b0;
        $display("alloc rd=%0d br=%0b pred=%0b -> rob_id=%0d full=%0b", rd, br, pr, rob_id, full);
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val, input logic tk);
        cdb_en = 1'b1; cdb_id = id; cdb_val = val; cdb_tk = tk;
        tick();
        cdb_en = 1'b0;
        $display("cdb id=%0d val=0x%0h taken=%0b", id, val, tk);
    endtask

    task automatic commit_chk(input string tag, input logic [5:0] rd,
                              input logic [4:0] q, input logic [31:0] v);
        $display("commit %s en=%0b rd=%0d Q=%0d V=0x%0h", tag, en_reg, rd_reg, q_reg, v_reg);
        chk({tag, "_en"}, 32'(en_reg), 32'd1);
        chk({tag, "_rd"}, 32'(rd_reg), 32'(rd));
        chk({tag, "_q"},  32'(q_reg),  32'(q));
        chk({tag, "_v"},  v_reg, v);
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_en", 32'(en_reg), 32'd0);
        chk("rst_misp", 32'(misp), 32'd0);
        chk("rst_rd", 32'(rd_reg), 32'd32);
        chk("rst_q", 32'(q_reg), 32'd0);
        chk("rst_v", v_reg, 32'd0);
        chk("rst_rpc", rpc, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_robid", 32'(rob_id), 32'd1);

        // ---- single allocate / complete / commit ----
        alloc(6'd5, 1'b0, 1'b0, 32'd0);
        chk("t1_robid", 32'(rob_id), 32'd2);
        cdb(5'd1, 32'h2A, 1'b0);
        chk("t1_en_early", 32'(en_reg), 32'd0);
        qj = 5'd1; #1;
        chk("t1_qj_rdy", 32'(qj_rdy), 32'd1);
        chk("t1_vj", vj, 32'h2A);
        tick();
        commit_chk("t1", 6'd5, 5'd1, 32'h2A);
        tick();
        chk("t1_en_drop", 32'(en_reg), 32'd0);
        chk("t1_qj_retired", 32'(qj_rdy), 32'd0);
        chk("t1_vj_retired", vj, 32'd0);
        qj = '0;

        // ---- fill to capacity ----
        do_reset();
        for (int i = 0; i < 16; i++) alloc(6'(i + 1), 1'b0, 1'b0, 32'd0);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_robid_full", 32'(rob_id), 32'd1);
        alloc(6'd20, 1'b0, 1'b0, 32'd0);
        chk("t2_full_17", 32'(full), 32'd1);
        chk("t2_robid_17", 32'(rob_id), 32'd1);
        cdb(5'd1, 32'h11, 1'b0);
        // Allocation at the commit edge is still refused: count was 16.
        alloc(6'd21, 1'b0, 1'b0, 32'd0);
        commit_chk("t2", 6'd1, 5'd1, 32'h11);
        chk("t2_full_after", 32'(full), 32'd0);
        chk("t2_robid_after", 32'(rob_id), 32'd1);
        alloc(6'd22, 1'b0, 1'b0, 32'd0);
        chk("t2_refull", 32'(full), 32'd1);
        chk("t2_robid_refull", 32'(rob_id), 32'd2);

        // ---- out-of-order completion, in-order retire ----
        do_reset();
        alloc(6'd7, 1'b0, 1'b0, 32'd0);
        alloc(6'd8, 1'b0, 1'b0, 32'd0);
        alloc(6'd9, 1'b0, 1'b0, 32'd0);
        cdb(5'd3, 32'd3, 1'b0);
        cdb(5'd2, 32'd7, 1'b0);
        chk("t3_en_wait", 32'(en_reg), 32'd0);
        qj = 5'd2; qk = 5'd3; #1;
        chk("t3_qj_rdy", 32'(qj_rdy), 32'd1);
        chk("t3_vj", vj, 32'd7);
        chk("t3_qk_rdy", 32'(qk_rdy), 32'd1);
        chk("t3_vk", vk, 32'd3);
        qj = 5'd1; #1;
        chk("t3_qj1_rdy", 32'(qj_rdy), 32'd0);
        qj = '0; qk = '0;
        cdb(5'd1, 32'd1, 1'b0);
        chk("t3_en_still", 32'(en_reg), 32'd0);
        tick(); commit_chk("t3_c1", 6'd7, 5'd1, 32'd1);
        tick(); commit_chk("t3_c2", 6'd8, 5'd2, 32'd7);
        tick(); commit_chk("t3_c3", 6'd9, 5'd3, 32'd3);
        tick();
        chk("t3_en_drop", 32'(en_reg), 32'd0);

        // ---- branch mispredict flush ----
        do_reset();
        alloc(6'd32, 1'b1, 1'b0, 32'h1000);
        alloc(6'd4, 1'b0, 1'b0, 32'd0);
        cdb(5'd1, 32'd0, 1'b1);
        alloc(6'd6, 1'b0, 1'b0, 32'd0);
        $display("flush misp=%0b redirect=0x%0h", misp, rpc);
        chk("t4_misp", 32'(misp), 32'd1);
        chk("t4_rpc", rpc, 32'h1000);
        chk("t4_full", 32'(full), 32'd0);
        chk("t4_robid", 32'(rob_id), 32'd1);
        chk("t4_en", 32'(en_reg), 32'd0);
        alloc_en = 1'b1; rd_in = 6'd6;
        cdb(5'd2, 32'd5, 1'b0);
        alloc_en = 1'b0;
        chk("t4_misp_drop", 32'(misp), 32'd0);
        chk("t4_robid_pulse", 32'(rob_id), 32'd1);
        qj = 5'd2; #1;
        chk("t4_qj2_rdy", 32'(qj_rdy), 32'd0);
        qj = '0;

        // ---- operand query vs live CDB ----
        do_reset();
        alloc(6'd1, 1'b0, 1'b0, 32'd0);
        alloc(6'd2, 1'b0, 1'b0, 32'd0);
        alloc(6'd3, 1'b0, 1'b0, 32'd0);
        cdb_en = 1'b1; cdb_id = 5'd3; cdb_val = 32'd9; qj = 5'd3; #1;
        $display("query Qj=3 during cdb(3,9): ready=%0b V=%0d", qj_rdy, vj);
`ifdef ROB_CDB_BYPASS_EN
        chk("t5_byp_rdy", 32'(qj_rdy), 32'd1);
        chk("t5_byp_v", vj, 32'd9);
`else
        chk("t5_nobyp_rdy", 32'(qj_rdy), 32'd0);
        chk("t5_nobyp_v", vj, 32'd0);
`endif
        tick();
        cdb_en = 1'b0; #1;
        chk("t5_late_rdy", 32'(qj_rdy), 32'd1);
        chk("t5_late_v", vj, 32'd9);
        qj = '0;

        // ---- rdy freeze ----
        do_reset();
        alloc(6'd5, 1'b0, 1'b0, 32'd0);
        alloc(6'd6, 1'b0, 1'b0, 32'd0);
        cdb(5'd1, 32'h55, 1'b0);
        cdb(5'd2, 32'h66, 1'b0);
        commit_chk("t6_c1", 6'd5, 5'd1, 32'h55);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            commit_chk("t6_hold", 6'd5, 5'd1, 32'h55);
        end
        rdy = 1'b1;
        tick();
        commit_chk("t6_c2", 6'd6, 5'd2, 32'h66);
        tick();
        chk("t6_en_drop", 32'(en_reg), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
